// File: rtl/meter_display.sv
// rtl/meter_display.sv - 4-digit multiplexed 7-segment driver with frame shadow and low-time blink
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits above the ones digit.

module meter_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int FLASH_DIV   = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] count_bcd,
  input  logic        flash,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST   = FW'(FLASH_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } phase_e;

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          flash_q;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  phase_e        phase_q, phase_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          refresh_tc;
  logic          flash_tc;
  logic [3:0]    nibble;
  logic          lz_blank;

  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    case (d)
      4'd0:    decode_digit = 7'b1000000;
      4'd1:    decode_digit = 7'b1111001;
      4'd2:    decode_digit = 7'b0100100;
      4'd3:    decode_digit = 7'b0110000;
      4'd4:    decode_digit = 7'b0011001;
      4'd5:    decode_digit = 7'b0010010;
      4'd6:    decode_digit = 7'b0000010;
      4'd7:    decode_digit = 7'b1111000;
      4'd8:    decode_digit = 7'b0000000;
      4'd9:    decode_digit = 7'b0010000;
      default: decode_digit = SEG_DASH;
    endcase
  endfunction

  // Shadow only reloads on the 3->0 wrap so a frame never mixes two counts.
  always_comb begin
    refresh_tc    = (refresh_cnt_q == REFRESH_LAST);
    refresh_cnt_d = refresh_tc ? '0 : refresh_cnt_q + 1'b1;
    digit_d       = refresh_tc ? digit_q + 2'd1 : digit_q;
    shadow_d      = (refresh_tc && digit_q == 2'd3) ? count_bcd : shadow_q;
  end

  // Holding the counter at 0 with phase ON while flash is low makes every
  // registered rising edge start a fresh ON half-period.
  always_comb begin
    flash_tc    = (flash_cnt_q == FLASH_LAST);
    flash_cnt_d = flash_cnt_q;
    phase_d     = phase_q;
    if (!flash_q) begin
      flash_cnt_d = '0;
      phase_d     = PHASE_ON;
    end else if (flash_tc) begin
      flash_cnt_d = '0;
      phase_d     = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
    end else begin
      flash_cnt_d = flash_cnt_q + 1'b1;
    end
  end

  always_comb begin
    case (digit_q)
      2'd0:    nibble = shadow_q[3:0];
      2'd1:    nibble = shadow_q[7:4];
      2'd2:    nibble = shadow_q[11:8];
      default: nibble = shadow_q[15:12];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    lz_blank = ((digit_q == 2'd3) && (shadow_q[15:12] == 4'd0)) ||
               ((digit_q == 2'd2) && (shadow_q[15:8]  == 8'd0)) ||
               ((digit_q == 2'd1) && (shadow_q[15:4]  == 12'd0));
`else
    lz_blank = 1'b0;
`endif
  end

  // Blank gating uses flash_q directly so a drop in flash reaches the anodes in two clocks.
  always_comb begin
    an_d  = (flash_q && phase_q == PHASE_OFF) ? 4'b1111 : ~(4'b0001 << digit_q);
    seg_d = lz_blank ? SEG_BLANK : decode_digit(nibble);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt_q <= '0;
      digit_q       <= 2'd0;
      shadow_q      <= 16'h0000;
      flash_q       <= 1'b0;
      flash_cnt_q   <= '0;
      phase_q       <= PHASE_ON;
      seg_q         <= SEG_BLANK;
      an_q          <= 4'b1111;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      digit_q       <= digit_d;
      shadow_q      <= shadow_d;
      flash_q       <= flash;
      flash_cnt_q   <= flash_cnt_d;
      phase_q       <= phase_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_meter_display.sv
// tb/tb_meter_display.sv - scoreboard bench for meter_display with a cycle-count reference model
// Build with LEADING_ZERO_BLANK_EN defined to exercise leading-zero blanking.

module tb_meter_display;

  localparam int R = 4;
  localparam int F = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] count_bcd = 16'h0000;
  logic        flash = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  meter_display #(.REFRESH_DIV(R), .FLASH_DIV(F)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_bcd (count_bcd),
    .flash     (flash),
    .seg       (seg),
    .an        (an)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Model state: edges since reset release, displayed frame value, registered flash, flash run length.
  int          n = 0;
  logic [15:0] frame_m = 16'h0000;
  logic        fq = 1'b0;
  int          run = 0;

  always @(posedge clk) begin
    exp_t e;
    int   idx;
    int   nib;
    bit   lz;
    if (reset) begin
      n = 0; frame_m = 16'h0000; fq = 1'b0; run = 0;
      e.an = 4'b1111; e.seg = 7'b1111111;
    end else begin
      n++;
      idx = ((n - 1) / R) % 4;
      nib = int'(frame_m[idx*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      lz = (idx > 0) && ((frame_m >> (idx * 4)) == 16'h0000);
`else
      lz = 1'b0;
`endif
      e.seg = lz ? 7'b1111111 : (nib < 10 ? seg_tab[nib] : 7'b0111111);
      e.an  = (fq && (((run - 1) / F) % 2 == 1)) ? 4'b1111 : ~(4'b0001 << idx);
      if (n % (4 * R) == 0) frame_m = count_bcd;
      fq  = flash;
      run = flash ? run + 1 : 0;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({an, seg} !== {e.an, e.seg}) begin
        miscompares++;
        $display("FAIL display t=%0t edge=%0d: an=%b seg=%b, expected an=%b seg=%b",
                 $time, n, an, seg, e.an, e.seg);
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic async_reset_check();
    reset = 1'b1;
    #1;
    vectors++;
    if ({an, seg} !== {4'b1111, 7'b1111111}) begin
      miscompares++;
      $display("FAIL async_reset: an=%b seg=%b, expected an=1111 seg=1111111", an, seg);
    end
    step(2);
    reset = 1'b0;
  endtask

  function automatic logic [15:0] rand_count();
    logic [15:0] v;
    if ($urandom_range(0, 3) == 0) begin
      v = 16'($urandom);
    end else begin
      v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
           4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 3) == 0) v[15:8] = 8'h00;
    end
    return v;
  endfunction

  initial begin
    step(3);
    reset = 1'b0;
    step(6);
    async_reset_check();

    count_bcd = 16'h1234;
    step(2 * 4 * R);
    step(R + 2);
    count_bcd = 16'h5678;
    step(3 * 4 * R);

    flash = 1'b1;
    step(100);
    flash = 1'b0;
    step(10);

    count_bcd = 16'h00A9;
    step(3 * 4 * R);
    count_bcd = 16'h0000;
    step(3 * 4 * R);
    count_bcd = 16'h0405;
    step(3 * 4 * R);

    for (int i = 0; i < 120; i++) begin
      count_bcd = rand_count();
      step(1);
    end

    step(7);
    async_reset_check();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) count_bcd = rand_count();
      if ($urandom_range(0, 59) == 0) flash = ~flash;
      step(1);
    end

    flash = 1'b0;
    step(4);
    vectors++;
    if (exp_q.size() > 1) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected at most 1", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
